// File: rtl/rgb_pwm_pkg.sv
// Shared defaults and helpers for the rgb_pwm block.
// Optional fading toward new on-times is enabled with the RGB_PWM_FADE_EN macro.
package rgb_pwm_pkg;

    localparam int          RGB_CHANNELS  = 3;
    localparam int          RGB_WIDTH     = 16;
    localparam logic [15:0] RGB_FADE_STEP = 16'd64;

    // Output level of an extinguished LED (pins are active-low).
    localparam logic        PWM_OFF       = 1'b1;

    // Width of one channel's slice in the packed on-time word.
    localparam int          RGB_SLICE_W   = RGB_WIDTH;

    function automatic int ch_lsb(input int ch, input int width);
        return ch * width;
    endfunction

endpackage

// File: rtl/rgb_pwm_channel.sv
// One PWM channel: staging register, frame-aligned active register and registered compare.
// With RGB_PWM_FADE_EN defined, active approaches staging by at most FADE_STEP per frame.
module pwm_channel
    import rgb_pwm_pkg::*;
#(
    parameter int               WIDTH     = RGB_WIDTH,
    parameter logic [WIDTH-1:0] FADE_STEP = WIDTH'(RGB_FADE_STEP)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             safe,
    input  logic             wrap,
    input  logic [WIDTH-1:0] on_time,
    input  logic [WIDTH-1:0] counter,
    output logic             pwm_out
);

    logic [WIDTH-1:0] staging;
    logic [WIDTH-1:0] active;
    logic [WIDTH-1:0] next_active;

    // Signed difference in WIDTH+1 bits cannot overflow for unsigned WIDTH-bit operands.
    function automatic logic [WIDTH-1:0] fade_toward(input logic [WIDTH-1:0] target,
                                                     input logic [WIDTH-1:0] cur);
        logic signed [WIDTH:0] diff;
        logic signed [WIDTH:0] step;
        diff = $signed({1'b0, target}) - $signed({1'b0, cur});
        step = $signed({1'b0, FADE_STEP});
        if (diff > step) begin
            return cur + FADE_STEP;
        end else if (diff < -step) begin
            return cur - FADE_STEP;
        end else begin
            return target;
        end
    endfunction

`ifdef RGB_PWM_FADE_EN
    assign next_active = fade_toward(staging, active);
`else
    assign next_active = staging;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            staging <= '0;
            active  <= '0;
            pwm_out <= PWM_OFF;
        end else begin
            if (safe) begin
                staging <= on_time;
            end
            if (wrap) begin
                active <= next_active;
            end
            pwm_out <= (counter < active) ? 1'b0 : 1'b1;
        end
    end

endmodule

// File: rtl/rgb_pwm.sv
// Three-channel active-low PWM with tear-free on-time staging and frame-aligned updates.
// Define RGB_PWM_FADE_EN to limit the per-frame on-time change to FADE_STEP.
module rgb_pwm
    import rgb_pwm_pkg::*;
#(
    parameter int               CHANNELS  = RGB_CHANNELS,
    parameter int               WIDTH     = RGB_WIDTH,
    parameter logic [WIDTH-1:0] FADE_STEP = WIDTH'(RGB_FADE_STEP)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      ramSafe,
    input  logic [CHANNELS*WIDTH-1:0] onTimes,
    input  logic [WIDTH-1:0]          period,
    output logic [CHANNELS-1:0]       pwmOut,
    output logic                      frameStart
);

    logic             sync_p0;
    logic             safeS;
    logic [WIDTH-1:0] counter;
    logic [WIDTH-1:0] periodQ;
    logic             wrap;
    logic             wrapped_p1;

    assign wrap = (counter == periodQ);

    // Stage 0: ramSafe synchronizer, frame counter and period latch.
    // Stage 1: wrapped_p1 marks counter==0 reached through a wrap; frameStart then
    // lines up with the output register showing that count.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_p0    <= 1'b0;
            safeS      <= 1'b0;
            counter    <= '0;
            periodQ    <= '1;
            wrapped_p1 <= 1'b0;
            frameStart <= 1'b0;
        end else begin
            sync_p0    <= ramSafe;
            safeS      <= sync_p0;
            counter    <= wrap ? '0 : counter + 1'b1;
            if (wrap) begin
                periodQ <= period;
            end
            wrapped_p1 <= wrap;
            frameStart <= wrapped_p1;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        localparam int LSB = ch_lsb(i, WIDTH);
        pwm_channel #(
            .WIDTH     (WIDTH),
            .FADE_STEP (FADE_STEP)
        ) u_ch (
            .clock   (clock),
            .reset   (reset),
            .safe    (safeS),
            .wrap    (wrap),
            .on_time (onTimes[LSB +: WIDTH]),
            .counter (counter),
            .pwm_out (pwmOut[i])
        );
    end

endmodule

// File: tb/tb_rgb_pwm.sv
// Self-checking bench for rgb_pwm: expected per-frame duty records are queued as stimulus
// is applied and compared against the measured frames; fade expectations follow RGB_PWM_FADE_EN.
module tb_rgb_pwm;

    logic        clock = 1'b0;
    logic        reset;
    logic        ramSafe;
    logic [47:0] onTimes;
    logic [15:0] period;
    logic [2:0]  pwmOut;
    logic        frameStart;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int len;
        int low0;
        int low1;
        int low2;
    } frame_t;

    frame_t exp_q[$];

    rgb_pwm dut (
        .clock      (clock),
        .reset      (reset),
        .ramSafe    (ramSafe),
        .onTimes    (onTimes),
        .period     (period),
        .pwmOut     (pwmOut),
        .frameStart (frameStart)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic expect_frame(input int len, input int l0, input int l1, input int l2);
        frame_t f;
        f.len  = len;
        f.low0 = l0;
        f.low1 = l1;
        f.low2 = l2;
        exp_q.push_back(f);
    endtask

    // Called on a negedge where frameStart is high; returns on the next such negedge.
    task automatic measure_frame(output frame_t f);
        f.len = 0; f.low0 = 0; f.low1 = 0; f.low2 = 0;
        forever begin
            f.low0 += int'(!pwmOut[0]);
            f.low1 += int'(!pwmOut[1]);
            f.low2 += int'(!pwmOut[2]);
            f.len++;
            @(negedge clock);
            if (frameStart) break;
            if (f.len >= 1000) begin
                check_eq("frame_timeout", f.len, -1);
                break;
            end
        end
    endtask

    task automatic check_frames(input int n);
        frame_t got;
        frame_t exp;
        for (int k = 0; k < n; k++) begin
            measure_frame(got);
            if (exp_q.size() == 0) begin
                check_eq("queue_empty", 0, 1);
            end else begin
                exp = exp_q.pop_front();
                check_eq("frame_len", got.len,  exp.len);
                check_eq("low_ch0",   got.low0, exp.low0);
                check_eq("low_ch1",   got.low1, exp.low1);
                check_eq("low_ch2",   got.low2, exp.low2);
            end
        end
    endtask

    initial begin
        int n;
        int fade_up[5];
        int fade_dn[4];
`ifdef RGB_PWM_FADE_EN
        fade_up = '{64, 128, 192, 200, 200};
        fade_dn = '{136, 72, 8, 0};
`else
        fade_up = '{200, 200, 200, 200, 200};
        fade_dn = '{0, 0, 0, 0};
`endif
        reset   = 1'b1;
        ramSafe = 1'b1;
        period  = 16'd9;
        onTimes = {16'd10, 16'd0, 16'd5};
        repeat (3) @(negedge clock);
        check_eq("reset_pwm",   int'(pwmOut), 7);
        check_eq("reset_frame", int'(frameStart), 0);

        // First wrap after reset uses the all-ones period latch.
        reset = 1'b0;
        n = 0;
        while (n < 70000) begin
            @(negedge clock);
            n++;
            if (frameStart) break;
        end
        check_eq("first_frame_start", n, 65537);

        // Basic duty: ch0 5 low, ch1 off, ch2 beyond period so always on.
        repeat (3) expect_frame(10, 5, 0, 10);
        check_frames(3);

        // Changes while chip-select is active are held back.
        ramSafe = 1'b0;
        expect_frame(10, 5, 0, 10);
        check_frames(1);
        onTimes = {16'd10, 16'd0, 16'd7};
        repeat (2) expect_frame(10, 5, 0, 10);
        check_frames(2);
        ramSafe = 1'b1;
        expect_frame(10, 5, 0, 10);
        expect_frame(10, 7, 0, 10);
        expect_frame(10, 7, 0, 10);
        check_frames(3);

        // period==0: every cycle is a frame.
        period  = 16'd0;
        onTimes = {16'd10, 16'd0, 16'd1};
        expect_frame(10, 7, 0, 10);
        repeat (5) expect_frame(1, 1, 0, 1);
        check_frames(6);

        // Back to period 9; staging reaches the compare only after the following wrap.
        period  = 16'd9;
        onTimes = {16'd10, 16'd0, 16'd5};
        expect_frame(1, 1, 0, 1);
        expect_frame(1, 1, 0, 1);
        expect_frame(10, 1, 0, 10);
        expect_frame(10, 5, 0, 10);
        check_frames(4);

        // Long frames for the fade sequence.
        period  = 16'd255;
        onTimes = '0;
        expect_frame(10, 5, 0, 10);
        check_frames(1);
        onTimes = {16'd0, 16'd0, 16'd200};
        expect_frame(256, 0, 0, 0);
        for (int k = 0; k < 4; k++) expect_frame(256, fade_up[k], 0, 0);
        check_frames(5);
        onTimes = '0;
        expect_frame(256, fade_up[4], 0, 0);
        for (int k = 0; k < 4; k++) expect_frame(256, fade_dn[k], 0, 0);
        check_frames(5);

        // Reset mid-frame while ch0 is driving low.
        onTimes = {16'd0, 16'd0, 16'd100};
        expect_frame(256, 0, 0, 0);
        check_frames(1);
        repeat (20) @(negedge clock);
        check_eq("midframe_ch0_on", int'(pwmOut[0]), 0);
        reset = 1'b1;
        @(negedge clock);
        check_eq("midreset_pwm",   int'(pwmOut), 7);
        check_eq("midreset_frame", int'(frameStart), 0);
        @(negedge clock);
        check_eq("midreset_pwm2",   int'(pwmOut), 7);
        check_eq("midreset_frame2", int'(frameStart), 0);
        check_eq("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
